// File: rtl/decode_stage.sv
// Pipelined register-read decode: private register file, busy scoreboard for
// RAW/WAW stalls, optional write-back bypass, and a registered valid/ready output.
module decode_stage #(
  parameter int XLEN      = 32,
  parameter int REG_NUM   = 32,
  parameter int BYPASS_EN = 1,
  localparam int AW       = $clog2(REG_NUM)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      instr_type_i,
  input  logic [AW-1:0]   rs1_i,
  input  logic [AW-1:0]   rs2_i,
  input  logic [AW-1:0]   rd_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            wb_en_i,
  input  logic [AW-1:0]   wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [2:0]      instr_type_o,
  output logic [AW-1:0]   rd_o,
  output logic [XLEN-1:0] val1_o,
  output logic [XLEN-1:0] val2_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] pc_o
);
  localparam logic [2:0] TYPER = 3'd0, TYPEI = 3'd1, TYPES = 3'd2,
                         TYPEB = 3'd3, TYPEU = 3'd4, TYPEJ = 3'd5;
  localparam logic BP = (BYPASS_EN != 0);

  logic [XLEN-1:0]    rf [REG_NUM];
  logic [REG_NUM-1:0] busy;

  logic            use_rs1, use_rs2, writes_rd;
  logic            hit1, hit2, clr_rd, hazard, accept, wb_wr;
  logic [XLEN-1:0] val1, val2;

  always_comb begin
    use_rs1   = (instr_type_i == TYPER) || (instr_type_i == TYPEI) ||
                (instr_type_i == TYPES) || (instr_type_i == TYPEB);
    use_rs2   = (instr_type_i == TYPER) || (instr_type_i == TYPES) ||
                (instr_type_i == TYPEB);
    writes_rd = ((instr_type_i == TYPER) || (instr_type_i == TYPEI) ||
                 (instr_type_i == TYPEU) || (instr_type_i == TYPEJ)) && (rd_i != '0);
    wb_wr     = wb_en_i && (wb_rd_i != '0);
    hit1      = BP && wb_en_i && (wb_rd_i == rs1_i) && (rs1_i != '0);
    hit2      = BP && wb_en_i && (wb_rd_i == rs2_i) && (rs2_i != '0);
    clr_rd    = wb_en_i && (wb_rd_i == rd_i);
    hazard    = (use_rs1 && busy[rs1_i] && !hit1) ||
                (use_rs2 && busy[rs2_i] && !hit2) ||
                (writes_rd && busy[rd_i] && !(BP && clr_rd));
    in_ready_o = (!out_valid_o || out_ready_i) && !hazard;
    accept     = in_valid_i && in_ready_o;
    // rf[0] is never written, so it reads 0 without a special case.
    val1 = '0;
    val2 = '0;
    if (use_rs1) val1 = hit1 ? wb_data_i : rf[rs1_i];
    if (use_rs2) val2 = hit2 ? wb_data_i : rf[rs2_i];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < REG_NUM; i++) rf[i] <= '0;
      busy <= '0;
    end else begin
      if (wb_wr) begin
        rf[wb_rd_i]   <= wb_data_i;
        busy[wb_rd_i] <= 1'b0;
      end
      // Issue after write-back so a same-index set wins over the clear.
      if (accept && writes_rd) busy[rd_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o  <= 1'b0;
      instr_type_o <= '0;
      rd_o         <= '0;
      val1_o       <= '0;
      val2_o       <= '0;
      imm_o        <= '0;
      pc_o         <= '0;
    end else if (accept) begin
      out_valid_o  <= 1'b1;
      instr_type_o <= instr_type_i;
      rd_o         <= rd_i;
      val1_o       <= val1;
      val2_o       <= val2;
      imm_o        <= imm_i;
      pc_o         <= pc_i;
    end else if (out_valid_o && out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end
endmodule
